// File: rtl/rv32v_types_pkg.sv
// Shared types for the divider front-end: the arbiter FSM state encoding.
package rv32v_types_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RESP,
    DRAIN
  } div_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector; prio_ptr names the lane that currently has highest priority.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] prio_ptr,
  output logic [NREQ-1:0] gnt
);

  logic [PTRW-1:0] idx;
  logic            found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PTRW'((32'(prio_ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Multi-lane front-end for a shared iterative divider: arbitrates, short-circuits
// divide-by-zero / signed overflow, and routes the result back to the requesting lane.
module div_arbiter
  import rv32v_types_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0][WIDTH-1:0]  dividend,
  input  logic [NREQ-1:0][WIDTH-1:0]  divisor,
  input  logic [NREQ-1:0]             is_signed,
  input  logic [NREQ-1:0]             div_type,
  input  logic                        flush,
  output logic [NREQ-1:0]             gnt,
  output logic [NREQ-1:0]             resp_valid,
  output logic [WIDTH-1:0]            resp_data,
  output logic                        resp_dz,
  output logic                        busy,
  output logic [WIDTH-1:0]            div_dividend,
  output logic [WIDTH-1:0]            div_divisor,
  output logic                        div_is_signed,
  output logic                        div_start,
  input  logic                        div_finished,
  input  logic [WIDTH-1:0]            div_quotient,
  input  logic [WIDTH-1:0]            div_remainder
);

  localparam int unsigned     PTRW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_arb_state_t  state, state_nx;
  logic [PTRW-1:0] prio_ptr, ptr_nx, lane, gnt_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [WIDTH-1:0] sel_dividend, sel_divisor, res_q, res_r;
  logic            sel_signed, sel_type, sel_dz, sel_ovf, grant;
  logic            op_type, op_dz;

  rr_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) u_rr (
    .req      (req),
    .prio_ptr (prio_ptr),
    .gnt      (arb_gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (arb_gnt[i]) gnt_idx = PTRW'(i);
  end

  assign sel_dividend = dividend[gnt_idx];
  assign sel_divisor  = divisor[gnt_idx];
  assign sel_signed   = is_signed[gnt_idx];
  assign sel_type     = div_type[gnt_idx];
  assign sel_dz       = (sel_divisor == '0);
  assign sel_ovf      = sel_signed && (sel_dividend == INT_MIN) && (sel_divisor == '1);
  // Gated by RST so no acceptance pulse escapes while reset is held.
  assign grant        = (state == IDLE) && (|req) && !RST;
  assign ptr_nx       = (gnt_idx == PTRW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (grant) state_nx = (sel_dz || sel_ovf) ? RESP : START;
      START: state_nx = flush ? IDLE : WAIT;
      // A flush coinciding with the done pulse has nothing left to drain.
      WAIT:  if (flush)             state_nx = div_finished ? IDLE : DRAIN;
             else if (div_finished) state_nx = RESP;
      RESP:  state_nx = IDLE;
      DRAIN: if (div_finished) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt        = '0;
    resp_valid = '0;
    resp_data  = '0;
    resp_dz    = 1'b0;
    div_start  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (grant) gnt = arb_gnt;
      START: div_start = !flush;
      RESP:  if (!flush) begin
               resp_valid[lane] = 1'b1;
               resp_data        = op_type ? res_q : res_r;
               resp_dz          = op_dz;
             end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prio_ptr      <= '0;
      lane          <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      div_is_signed <= 1'b0;
      op_type       <= 1'b0;
      op_dz         <= 1'b0;
      res_q         <= '0;
      res_r         <= '0;
    end else if (grant) begin
      prio_ptr      <= ptr_nx;
      lane          <= gnt_idx;
      div_dividend  <= sel_dividend;
      div_divisor   <= sel_divisor;
      div_is_signed <= sel_signed;
      op_type       <= sel_type;
      op_dz         <= sel_dz;
      // Bypass results; a normal division overwrites these when it finishes.
      res_q         <= sel_dz ? '1 : sel_dividend;
      res_r         <= sel_dz ? sel_dividend : '0;
    end else if (state == WAIT && div_finished) begin
      res_q <= div_quotient;
      res_r <= div_remainder;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: emulates the iterative divider, keeps a transaction-level
// model of the front-end and compares every cycle, plus directed literal scenarios.
module tb_div_arbiter;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned WIDTH = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [NREQ-1:0]            req       = '0;
  logic [NREQ-1:0][WIDTH-1:0] dividend  = '0;
  logic [NREQ-1:0][WIDTH-1:0] divisor   = '0;
  logic [NREQ-1:0]            is_signed = '0;
  logic [NREQ-1:0]            div_type  = '0;
  logic                       flush     = 1'b0;
  logic [NREQ-1:0]            gnt, resp_valid;
  logic [WIDTH-1:0]           resp_data, div_dividend, div_divisor;
  logic                       resp_dz, busy, div_is_signed, div_start;
  logic                       div_finished = 1'b0;
  logic [WIDTH-1:0]           div_quotient = '0, div_remainder = '0;

  always #5 CLK = ~CLK;

  div_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .req(req), .dividend(dividend), .divisor(divisor),
    .is_signed(is_signed), .div_type(div_type), .flush(flush), .gnt(gnt),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_dz(resp_dz), .busy(busy),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_is_signed(div_is_signed),
    .div_start(div_start), .div_finished(div_finished), .div_quotient(div_quotient),
    .div_remainder(div_remainder)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mathematical divide, truncating toward zero; returns {quotient, remainder}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  // Divider emulation: result appears dv_lat cycles after the start pulse, junk otherwise.
  int          dv_cnt       = 0;
  int          dv_lat_fixed = 0;
  logic [31:0] dv_q, dv_r;
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) dv_cnt = 0;
      else if (div_start) begin
        {dv_q, dv_r} = ref_div(div_dividend, div_divisor, div_is_signed);
        dv_cnt = (dv_lat_fixed != 0) ? dv_lat_fixed : int'($urandom_range(1, 6));
      end
      @(posedge CLK); #1;
      div_finished  = 1'b0;
      div_quotient  = $urandom;
      div_remainder = $urandom;
      if (dv_cnt > 0) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          div_finished  = 1'b1;
          div_quotient  = dv_q;
          div_remainder = dv_r;
        end
      end
    end
  end

  // Transaction-level model: what the front-end owes at each point of an operation.
  int unsigned m_prio = 0, m_lane = 0;
  bit          m_busy, m_need_start, m_in_div, m_drain, m_resp;
  logic [31:0] m_a = '0, m_b = '0, m_q, m_r;
  bit          m_sgn, m_typ, m_dz;
  int          m_g, cyc = 0;
  logic [NREQ-1:0] e_gnt, e_rv;
  int grant_log[$], grant_cyc[$], start_cyc[$], resp_lane[$], resp_cyc[$];
  logic [31:0] resp_dat[$];
  bit          resp_dzq[$];

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      chk("rst_gnt", gnt, 0);        chk("rst_resp_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);      chk("rst_div_start", div_start, 0);
      chk("rst_resp_dz", resp_dz, 0); chk("rst_resp_data", resp_data, 0);
      m_busy = 0; m_need_start = 0; m_in_div = 0; m_drain = 0; m_resp = 0;
      m_prio = 0; m_lane = 0; m_a = '0; m_b = '0; m_sgn = 0;
    end else begin
      m_g = -1;
      if (!m_busy)
        for (int unsigned k = 0; k < NREQ; k++)
          if (m_g < 0 && req[(m_prio + k) % NREQ]) m_g = int'((m_prio + k) % NREQ);
      e_gnt = (m_g >= 0) ? NREQ'(1) << m_g : '0;
      e_rv  = (m_resp && !flush) ? NREQ'(1) << m_lane : '0;
      chk("gnt", gnt, e_gnt);
      chk("resp_valid", resp_valid, e_rv);
      chk("resp_data", resp_data, (e_rv != 0) ? (m_typ ? m_q : m_r) : 32'd0);
      chk("resp_dz", resp_dz, (e_rv != 0) ? m_dz : 1'b0);
      chk("busy", busy, m_busy);
      chk("div_start", div_start, m_need_start && !flush);
      chk("div_dividend", div_dividend, m_a);
      chk("div_divisor", div_divisor, m_b);
      chk("div_is_signed", div_is_signed, m_sgn);
      if (gnt != 0) begin
        for (int k = 0; k < int'(NREQ); k++) if (gnt[k]) grant_log.push_back(k);
        grant_cyc.push_back(cyc);
      end
      if (div_start) start_cyc.push_back(cyc);
      if (resp_valid != 0) begin
        for (int k = 0; k < int'(NREQ); k++) if (resp_valid[k]) resp_lane.push_back(k);
        resp_cyc.push_back(cyc); resp_dat.push_back(resp_data); resp_dzq.push_back(resp_dz);
      end
      if (m_g >= 0) begin
        m_busy = 1; m_lane = m_g; m_prio = (m_g + 1) % NREQ;
        m_a = dividend[m_g]; m_b = divisor[m_g]; m_sgn = is_signed[m_g]; m_typ = div_type[m_g];
        if (m_b == 0) begin
          m_q = 32'hFFFF_FFFF; m_r = m_a; m_dz = 1; m_resp = 1;
        end else if (m_sgn && m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
          m_q = m_a; m_r = 0; m_dz = 0; m_resp = 1;
        end else begin
          {m_q, m_r} = ref_div(m_a, m_b, m_sgn); m_dz = 0; m_need_start = 1;
        end
      end else if (m_need_start) begin
        m_need_start = 0;
        if (flush) m_busy = 0; else m_in_div = 1;
      end else if (m_in_div) begin
        if (div_finished) begin
          m_in_div = 0;
          if (flush) m_busy = 0; else m_resp = 1;
        end else if (flush) begin
          m_in_div = 0; m_drain = 1;
        end
      end else if (m_resp) begin
        m_resp = 0; m_busy = 0;
      end else if (m_drain && div_finished) begin
        m_drain = 0; m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete(); start_cyc.delete();
    resp_lane.delete(); resp_cyc.delete(); resp_dat.delete(); resp_dzq.delete();
  endtask

  task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic t);
    dividend[l] = a; divisor[l] = b; is_signed[l] = s; div_type[l] = t;
  endtask

  task automatic do_reset();
    RST = 1'b1; req = '0; flush = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || req != 0) && n < budget) begin req = '0; tick(); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_resp(input int budget);
    int n = 0;
    while (resp_lane.size() == 0 && n < budget) begin tick(); n++; end
    chk("resp_timeout", resp_lane.size() > 0, 1);
  endtask

  // Single request on one lane; the bench checks the captured logs afterwards.
  task automatic run_op(input int l, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic t);
    clear_logs();
    set_lane(l, a, b, s, t);
    req = NREQ'(1) << l;
    tick();
    req = '0;
    wait_resp(30);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    do_reset();

    // Lane 0, 100/7 unsigned quotient, divider latency 5.
    dv_lat_fixed = 5;
    run_op(0, 32'd100, 32'd7, 1'b0, 1'b1);
    if (resp_lane.size() > 0 && grant_log.size() > 0 && start_cyc.size() > 0) begin
      chk("l0_gnt_lane", grant_log[0], 0);
      chk("l0_start_lat", start_cyc[0] - grant_cyc[0], 1);
      chk("l0_resp_lat", resp_cyc[0] - start_cyc[0], 6);
      chk("l0_resp_lane", resp_lane[0], 0);
      chk("l0_data", resp_dat[0], 32'd14);
      chk("l0_dz", resp_dzq[0], 0);
    end
    tick();

    // Divide by zero on lane 1, remainder then quotient.
    run_op(1, 32'h1234, 32'h0, 1'b0, 1'b0);
    if (resp_lane.size() > 0 && grant_cyc.size() > 0) begin
      chk("dz_resp_lat", resp_cyc[0] - grant_cyc[0], 1);
      chk("dz_lane", resp_lane[0], 1);
      chk("dz_rem", resp_dat[0], 32'h1234);
      chk("dz_flag", resp_dzq[0], 1);
      chk("dz_no_start", start_cyc.size(), 0);
    end
    tick();
    run_op(1, 32'h1234, 32'h0, 1'b0, 1'b1);
    if (resp_dat.size() > 0) chk("dz_quot", resp_dat[0], 32'hFFFF_FFFF);
    tick();

    // Signed overflow bypass.
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    if (resp_dat.size() > 0 && grant_cyc.size() > 0) begin
      chk("ovf_resp_lat", resp_cyc[0] - grant_cyc[0], 1);
      chk("ovf_quot", resp_dat[0], 32'h8000_0000);
      chk("ovf_dz", resp_dzq[0], 0);
      chk("ovf_no_start", start_cyc.size(), 0);
    end
    tick();
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    if (resp_dat.size() > 0) chk("ovf_rem", resp_dat[0], 32'h0);
    tick();

    // Both lanes requesting continuously from reset.
    do_reset();
    dv_lat_fixed = 0;
    clear_logs();
    set_lane(0, 32'd1000, 32'd3, 1'b0, 1'b1);
    set_lane(1, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
    req = 2'b11;
    seen = 0;
    while (resp_lane.size() < 4 && seen < 200) begin tick(); seen++; end
    req = '0;
    chk("rr_count", resp_lane.size() >= 4, 1);
    if (resp_lane.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_grant_seq", grant_log[i], i % 2);
        chk("rr_resp_seq", resp_lane[i], i % 2);
        chk("rr_resp_data", resp_dat[i], (i % 2 == 0) ? 32'd333 : 32'hFFFF_FFFE);
      end
    end
    wait_idle(50);

    // Flush two cycles into WAIT: drain until the divider finishes, then resume.
    dv_lat_fixed = 8;
    clear_logs();
    set_lane(0, 32'd5000, 32'd9, 1'b0, 1'b1);
    req = 2'b01;
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 0;
    while (grant_log.size() < 2 && seen < 40) begin tick(); seen++; end
    req = '0;
    chk("drain_regrant", grant_log.size() >= 2, 1);
    if (grant_log.size() >= 2) begin
      chk("drain_regrant_cyc", grant_cyc[1] - grant_cyc[0], 10);
      chk("drain_no_resp", resp_lane.size(), 0);
    end
    wait_resp(30);
    if (resp_dat.size() > 0) chk("drain_resume_data", resp_dat[0], 32'd555);
    wait_idle(50);

    // Reset during WAIT.
    clear_logs();
    set_lane(0, 32'd77, 32'd5, 1'b0, 1'b1);
    set_lane(1, 32'd88, 32'd5, 1'b0, 1'b1);
    req = 2'b01;
    tick();
    req = 2'b11;
    tick();
    RST = 1'b1;
    #1;
    chk("rstw_gnt", gnt, 0);             chk("rstw_resp_valid", resp_valid, 0);
    chk("rstw_div_start", div_start, 0); chk("rstw_busy", busy, 0);
    chk("rstw_resp_dz", resp_dz, 0);     chk("rstw_resp_data", resp_data, 0);
    chk("rstw_div_dividend", div_dividend, 0);
    chk("rstw_div_divisor", div_divisor, 0);
    tick();
    clear_logs();
    RST = 1'b0;
    tick();
    chk("rstw_first_grant_seen", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("rstw_first_grant", grant_log[0], 0);
    req = '0;
    wait_idle(50);

    // Randomized traffic against the model.
    dv_lat_fixed = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 599) == 0) RST = 1'b1;
      if ($urandom_range(0, 9) < 7) req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int l = 0; l < int'(NREQ); l++) begin
        case ($urandom_range(0, 5))
          0: set_lane(l, $urandom, 32'd0, 1'($urandom), 1'($urandom));
          1: set_lane(l, 32'h8000_0000, 32'hFFFF_FFFF, 1'($urandom), 1'($urandom));
          2: set_lane(l, $urandom_range(0, 1000), $urandom_range(1, 20), 1'($urandom), 1'($urandom));
          3: set_lane(l, $urandom, 32'hFFFF_FFFF - $urandom_range(0, 5), 1'($urandom), 1'($urandom));
          default: set_lane(l, $urandom, $urandom, 1'($urandom), 1'($urandom));
        endcase
      end
      flush = ($urandom_range(0, 15) == 0);
    end
    RST = 1'b0;
    flush = 1'b0;
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
